// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared helpers for the memory-port arbiter slice.
//   - tag_w    : bits needed to name one of n requesters (the read tag width).
//   - wrap_add : (base + off) mod n, used for round-robin index arithmetic.
//   The {valid, tag} and {we, addr, din} records are declared inside the
//   modules that use them, because their field widths follow each instance's
//   NUM_REQ / ADDR_WIDTH / DATA_WIDTH parameters.
package mem_arb_pkg;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick
//   Combinational round-robin picker. Searches upward from ptr (wrapping
//   NUM_REQ-1 -> 0) for the first set bit of elig.
// Ports:
//   elig  [NUM_REQ-1:0] requesters allowed to win this cycle
//   ptr   [PTR_W-1:0]   index with highest priority this cycle
//   win   [NUM_REQ-1:0] one-hot winner, all zero when nothing is eligible
//   found               a winner exists
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               found
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'(wrap_add(int'(ptr), i, NUM_REQ));
      if (!found && elig[cand]) begin
        win[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one RAM port among NUM_REQ requesters with round-robin priority,
//   issues one registered command per cycle, and routes each read's data back
//   to the requester that issued it.
//
// Handshake: requester k raises i_req[k] with i_we/i_addr/i_din stable and
//   keeps them stable until o_gnt[k] is seen (a one-cycle pulse coinciding with
//   the command on o_mem_*). In the grant cycle the request is masked, so the
//   requester may drop or reissue it freely. A read granted in cycle I returns
//   as a one-cycle o_rvalid[k] pulse with o_rdata in cycle I+RD_LATENCY+1;
//   returns keep issue order. Writes produce no return.
//
// Ports:
//   clk, i_rst_n            clock, synchronous active-low reset
//   i_req/i_we [NUM_REQ]    per-requester request and command type (1=write)
//   i_addr, i_din           packed per-requester address / write data
//   o_gnt [NUM_REQ]         one-hot grant
//   o_rvalid, o_rdata       one-hot read-return strobe and data
//   o_mem_en/we/addr/din    registered command toward the memory path
//   i_mem_dout              memory read data, valid RD_LATENCY after issue
//
// Build option MPA_RAW_STALL_EN: reads that hit the address of a write issued
//   fewer than WR_LATENCY cycles before their own issue cycle are held back
//   until the write is readable. Without it, such reads may see old data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_din,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_din,
  input  logic [DATA_WIDTH-1:0]         i_mem_dout
);

  localparam int TAG_W = tag_w(NUM_REQ);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] id;
  } rd_tag_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } mem_cmd_t;

  if (NUM_REQ < 2 || RD_LATENCY < 1 || WR_LATENCY < 1) begin : g_cfg_check
    $error("mem_port_arbiter: needs NUM_REQ >= 2, RD_LATENCY >= 1, WR_LATENCY >= 1");
  end

  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] hazard;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win;
  logic               found;
  mem_cmd_t           sel_cmd;

  // Stage 0 is loaded with the command, so stage j is valid in cycle I+j;
  // stage RD_LATENCY lines up with i_mem_dout for that read.
  rd_tag_t tag_pipe [RD_LATENCY+1];

`ifdef MPA_RAW_STALL_EN
  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
  } wr_ent_t;

  // Entry j holds a write issued j cycles ago. A read chosen now issues next
  // cycle, so only writes in entries 0..WR_LATENCY-2 are still unreadable.
  wr_ent_t wr_sr [WR_LATENCY];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < WR_LATENCY; j++) wr_sr[j] <= '0;
    end else begin
      wr_sr[0] <= '{vld: found & sel_cmd.we, addr: sel_cmd.addr};
      for (int j = 1; j < WR_LATENCY; j++) wr_sr[j] <= wr_sr[j-1];
    end
  end

  always_comb begin
    hazard = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < WR_LATENCY - 1; j++) begin
        if (!i_we[k] && wr_sr[j].vld &&
            wr_sr[j].addr == i_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
          hazard[k] = 1'b1;
        end
      end
    end
  end
`else
  assign hazard = '0;
`endif

  // Masking with o_gnt hides the request still held during its grant cycle.
  assign elig = i_req & ~o_gnt & ~hazard;

  mem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .win   (win),
    .found (found)
  );

  always_comb begin
    sel_cmd = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        sel_cmd.we   = i_we[k];
        sel_cmd.addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd.din  = i_din[k*DATA_WIDTH +: DATA_WIDTH];
        win_idx      = TAG_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      rr_ptr     <= '0;
      o_gnt      <= '0;
      o_mem_en   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
      o_rvalid   <= '0;
      o_rdata    <= '0;
      for (int j = 0; j <= RD_LATENCY; j++) tag_pipe[j] <= '0;
    end else begin
      o_gnt    <= win;
      o_mem_en <= found;
      o_mem_we <= found & sel_cmd.we;
      if (found) begin
        o_mem_addr <= sel_cmd.addr;
        o_mem_din  <= sel_cmd.din;
        rr_ptr     <= TAG_W'(wrap_add(int'(win_idx), 1, NUM_REQ));
      end

      tag_pipe[0] <= '{vld: found & ~sel_cmd.we, id: win_idx};
      for (int j = 1; j <= RD_LATENCY; j++) tag_pipe[j] <= tag_pipe[j-1];

      if (tag_pipe[RD_LATENCY].vld) begin
        o_rvalid <= NUM_REQ'(1) << tag_pipe[RD_LATENCY].id;
        o_rdata  <= i_mem_dout;
      end else begin
        o_rvalid <= '0;
      end
    end
  end

endmodule
